// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - instruction-memory fetch handshake between fetch unit and imem
interface fetch_pc_unit_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC / fetch stage: FETCH -> EXEC loop with misalign and timeout traps
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int          MAX_WAIT  = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   beq_out,
  input  logic                   bne_out,
  input  logic                   blt_out,
  input  logic                   bge_out,
  input  logic                   jal,
  input  logic                   alu_pc_sel,
  input  logic                   zero,
  input  logic                   lt,
  input  logic [31:0]            imm,
  input  logic [31:0]            alu_result,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            instr,
  output logic                   instr_valid,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic [31:0]            instret,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output logic [31:0]            trap_pc
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_TRAP  = 2'd2;

  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [31:0]   r_instret;
  logic [WW-1:0] r_wait;
  logic [1:0]    r_trap_cause;
  logic [31:0]   r_trap_pc;

  logic          w_taken;
  logic [31:0]   w_next_pc;
  logic          w_misaligned;

  always_comb begin
    w_taken = (beq_out & zero) | (bne_out & ~zero) | (blt_out & lt) | (bge_out & ~lt);
    if (alu_pc_sel) begin
      w_next_pc = {alu_result[31:1], 1'b0};
    end else if (jal || w_taken) begin
      w_next_pc = r_pc + imm;
    end else begin
      w_next_pc = r_pc + 32'd4;
    end
    w_misaligned = (w_next_pc[1:0] != 2'b00);
  end

  // Request is gated by reset so an abandoned fetch never shows up during reset.
  assign imem.imem_req  = (r_state == S_FETCH) && !reset;
  assign imem.imem_addr = r_pc;

  assign instr       = r_instr;
  assign instr_valid = (r_state == S_EXEC);
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign instret     = r_instret;
  assign trap        = (r_state == S_TRAP);
  assign trap_cause  = r_trap_cause;
  assign trap_pc     = r_trap_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_instret    <= 32'd0;
      r_wait       <= '0;
      r_trap_cause <= 2'd0;
      r_trap_pc    <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem.imem_ack) begin
            r_instr <= imem.imem_rdata;
            r_wait  <= '0;
            r_state <= S_EXEC;
          end else if (r_wait == WAIT_LAST) begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_TIMEOUT;
            r_trap_pc    <= r_pc;
            r_instr      <= NOP_INSTR;
            r_wait       <= '0;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_EXEC: begin
          if (w_misaligned) begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_MISALIGN;
            r_trap_pc    <= w_next_pc;
            r_instr      <= NOP_INSTR;
          end else begin
            r_pc      <= w_next_pc;
            r_instret <= r_instret + 32'd1;
            r_state   <= S_FETCH;
          end
        end
        default: begin
          // TRAP (and the unused encoding) absorb until reset.
          r_state <= S_TRAP;
          r_instr <= NOP_INSTR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - randomized bench for fetch_pc_unit against a next-PC reference model
module tb_fetch_pc_unit;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        beq_out, bne_out, blt_out, bge_out, jal, alu_pc_sel, zero, lt;
  logic [31:0] imm, alu_result;
  logic [31:0] instr, pc, pc_plus4, instret, trap_pc;
  logic        instr_valid, trap;
  logic [1:0]  trap_cause;

  fetch_pc_unit_if u_if ();

  fetch_pc_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .beq_out(beq_out), .bne_out(bne_out), .blt_out(blt_out), .bge_out(bge_out),
    .jal(jal), .alu_pc_sel(alu_pc_sel), .zero(zero), .lt(lt),
    .imm(imm), .alu_result(alu_result),
    .imem(u_if.master),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .instret(instret), .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;
  bit          trapped;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference next-PC: s = {alu_pc_sel, jal, beq, bne, blt, bge}
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [5:0] s,
                                             input logic z, input logic l,
                                             input logic [31:0] im, input logic [31:0] al);
    bit taken;
    taken = (s[3] && z) || (s[2] && !z) || (s[1] && l) || (s[0] && !l);
    if (s[5]) return al & 32'hFFFF_FFFE;
    if (s[4] || taken) return cur + im;
    return cur + 32'd4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [5:0] s, input logic z, input logic l,
                          input logic [31:0] im, input logic [31:0] al);
    {alu_pc_sel, jal, beq_out, bne_out, blt_out, bge_out} = s;
    zero = z; lt = l; imm = im; alu_result = al;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    u_if.imem_ack = 1'b0;
    u_if.imem_rdata = 32'd0;
    set_ctrl(6'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    check_val("rst_pc", pc, RESET_PC);
    check_val("rst_instr", instr, NOP);
    check_val("rst_valid", instr_valid, 0);
    check_val("rst_req", u_if.imem_req, 0);
    check_val("rst_instret", instret, 0);
    check_val("rst_trap", trap, 0);
    check_val("rst_cause", trap_cause, 0);
    check_val("rst_trap_pc", trap_pc, 0);
    reset = 1'b0;
    exp_pc = RESET_PC;
    exp_instret = 32'd0;
    trapped = 1'b0;
  endtask

  task automatic do_instr(input int delay, input logic [31:0] data, input logic [5:0] s,
                          input logic z, input logic l, input logic [31:0] im,
                          input logic [31:0] al);
    int n;
    logic [31:0] nxt;
    n = 0;
    while (u_if.imem_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check_val("req_seen", u_if.imem_req, 1);
    check_val("fetch_addr", u_if.imem_addr, exp_pc);
    check_val("valid_in_fetch", instr_valid, 0);
    repeat (delay) begin
      step();
      check_val("req_hold", u_if.imem_req, 1);
    end
    u_if.imem_ack = 1'b1;
    u_if.imem_rdata = data;
    step();
    u_if.imem_ack = 1'($urandom_range(0, 1));
    u_if.imem_rdata = $urandom;
    check_val("exec_valid", instr_valid, 1);
    check_val("exec_instr", instr, data);
    check_val("exec_pc", pc, exp_pc);
    check_val("exec_pc_plus4", pc_plus4, exp_pc + 32'd4);
    check_val("exec_req", u_if.imem_req, 0);
    set_ctrl(s, z, l, im, al);
    nxt = model_next(exp_pc, s, z, l, im, al);
    step();
    set_ctrl(6'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    u_if.imem_ack = 1'b0;
    check_val("post_valid", instr_valid, 0);
    if (nxt[1:0] != 2'b00) begin
      check_val("mis_trap", trap, 1);
      check_val("mis_cause", trap_cause, 1);
      check_val("mis_trap_pc", trap_pc, nxt);
      check_val("mis_pc", pc, exp_pc);
      check_val("mis_instret", instret, exp_instret);
      check_val("mis_instr", instr, NOP);
      u_if.imem_ack = 1'b1;
      repeat (3) begin
        step();
        check_val("trap_req", u_if.imem_req, 0);
        check_val("trap_valid", instr_valid, 0);
        check_val("trap_hold", {trap, trap_cause}, {1'b1, 2'd1});
      end
      u_if.imem_ack = 1'b0;
      trapped = 1'b1;
    end else begin
      exp_pc = nxt;
      exp_instret = exp_instret + 32'd1;
      check_val("next_pc", pc, exp_pc);
      check_val("instret", instret, exp_instret);
      check_val("next_req", u_if.imem_req, 1);
      check_val("no_trap", trap, 0);
    end
  endtask

  task automatic timeout_check(input string tag);
    int n;
    n = 0;
    u_if.imem_ack = 1'b0;
    while (trap !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_val({tag, "_cycles"}, n, MAX_WAIT);
    check_val({tag, "_cause"}, trap_cause, 2);
    check_val({tag, "_trap_pc"}, trap_pc, exp_pc);
    check_val({tag, "_instr"}, instr, NOP);
    check_val({tag, "_req"}, u_if.imem_req, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0]  s;
    logic [31:0] im, al;
    logic [11:0] off;

    do_reset();
    do_instr(2, 32'h0050_0093, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_val("tp1_pc", pc, 32'h0040_0004);

    do_reset();
    do_instr(0, 32'h0000_006F, 6'b010000, 1'b0, 1'b0, 32'h10, 32'd0);
    do_instr(1, 32'h0000_0063, 6'b001000, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0);
    check_val("beq_taken_pc", pc, 32'h0040_0008);
    do_instr(0, 32'h0000_006F, 6'b010000, 1'b0, 1'b0, 32'h8, 32'd0);
    do_instr(3, 32'h0000_0063, 6'b001000, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
    check_val("beq_not_taken_pc", pc, 32'h0040_0014);

    do_instr(0, 32'h0000_0067, 6'b110000, 1'b0, 1'b0, 32'h40, 32'h0040_0101);
    check_val("jalr_pc", pc, 32'h0040_0100);

    do_instr(0, 32'h0000_006F, 6'b010000, 1'b0, 1'b0, 32'hFFFF_FFFC - 32'h0040_0100, 32'd0);
    do_instr(0, 32'h0000_0013, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_val("pc_wrap", pc, 32'h0000_0000);

    do_reset();
    do_instr(0, 32'h0060_006F, 6'b010000, 1'b0, 1'b0, 32'h6, 32'd0);
    check_val("tp4_trap_pc", trap_pc, 32'h0040_0006);

    do_reset();
    timeout_check("to_reset");
    do_reset();
    do_instr(1, 32'h0000_0013, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    timeout_check("to_mid");

    do_reset();
    step();
    step();
    reset = 1'b1;
    u_if.imem_ack = 1'b1;
    u_if.imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    check_val("midrst_req", u_if.imem_req, 0);
    check_val("midrst_instr", instr, NOP);
    check_val("midrst_pc", pc, RESET_PC);
    reset = 1'b0;
    u_if.imem_ack = 1'b0;
    step();
    check_val("midrst_addr", u_if.imem_addr, RESET_PC);
    check_val("midrst_req_new", u_if.imem_req, 1);
    check_val("midrst_instr_nop", instr, NOP);
    exp_pc = RESET_PC;
    exp_instret = 32'd0;
    do_instr(1, 32'h1234_5013, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 250; i++) begin
      if (trapped) do_reset();
      case ($urandom_range(0, 3))
        0: s = 6'd0;
        1: s = 6'(6'd1 << $urandom_range(0, 5));
        2: s = 6'($urandom) & 6'b001111;
        default: s = 6'($urandom);
      endcase
      off = 12'($urandom) & 12'hFFC;
      if ($urandom_range(0, 7) == 0) im = $urandom;
      else im = {{20{off[11]}}, off};
      al = RESET_PC + ($urandom & 32'h0000_0FFF);
      do_instr($urandom_range(0, 3), $urandom, s, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), im, al);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
